// File: rtl/bp_update_ctrl.sv
// Update sequencer for the 2-bit saturating-counter branch history table: post-reset clear sweep,
// update FIFO and two-cycle read-modify-write. Optional BP_STATS_EN adds update/mispredict counters.
module bp_update_ctrl #(
  parameter int IDX_W      = 7,
  parameter int FIFO_DEPTH = 4
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             rdy_in,
  input  logic             upd_valid,
  input  logic [31:0]      upd_pc,
  input  logic             upd_taken,
  input  logic             upd_mispredict,
  output logic             upd_ready,
  output logic [IDX_W-1:0] tbl_raddr,
  input  logic [1:0]       tbl_rdata,
  output logic             tbl_we,
  output logic [IDX_W-1:0] tbl_waddr,
  output logic [1:0]       tbl_wdata,
`ifdef BP_STATS_EN
  output logic [31:0]      stat_updates,
  output logic [31:0]      stat_mispred,
`endif
  output logic             init_busy
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C    = CNT_W'(FIFO_DEPTH);
  localparam logic [IDX_W-1:0] SWEEP_LAST = {IDX_W{1'b1}};

  typedef enum logic [1:0] {
    S_INIT = 2'd0,
    S_IDLE = 2'd1,
    S_RD   = 2'd2,
    S_WR   = 2'd3
  } state_e;

  function automatic logic [1:0] sat_update(input logic [1:0] c, input logic taken);
    logic [1:0] r;
    if (taken) begin
      r = (c == 2'b11) ? 2'b11 : c + 2'b01;
    end else begin
      r = (c == 2'b00) ? 2'b00 : c - 2'b01;
    end
    return r;
  endfunction

  state_e           state_q, state_d;
  logic [IDX_W-1:0] sweep_q, sweep_d;
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q, count_d;
  logic [1:0]       cnt_q, cnt_d;
  logic             taken_q, taken_d;
  logic [IDX_W-1:0] fifo_idx_q   [FIFO_DEPTH];
  logic             fifo_taken_q [FIFO_DEPTH];

  logic             run_s, push_s, pop_s, pending_s;
  logic [IDX_W-1:0] head_idx_s;
  logic             unused_s;

  assign run_s      = rdy_in && !rst_in;
  assign upd_ready  = run_s && (count_q < DEPTH_C);
  assign push_s     = upd_valid && upd_ready;
  assign pop_s      = run_s && (state_q == S_WR);
  assign head_idx_s = fifo_idx_q[rd_ptr_q];
  assign tbl_raddr  = head_idx_s;
  assign init_busy  = rst_in || (state_q == S_INIT);
  assign count_d    = count_q + CNT_W'(push_s) - CNT_W'(pop_s);
  // Occupancy after this cycle's push/pop decides whether the next RMW starts immediately.
  assign pending_s  = (count_d != {CNT_W{1'b0}});

`ifdef BP_STATS_EN
  logic             fifo_mis_q [FIFO_DEPTH];
  logic [31:0]      stat_updates_q, stat_mispred_q;
  assign stat_updates = stat_updates_q;
  assign stat_mispred = stat_mispred_q;
  assign unused_s     = ^{upd_pc[31:IDX_W+2], upd_pc[1:0]};
`else
  assign unused_s     = ^{upd_pc[31:IDX_W+2], upd_pc[1:0], upd_mispredict};
`endif

  // Next-state selection for the sweep / idle / read / write sequence.
  always_comb begin
    state_d = state_q;
    sweep_d = sweep_q;
    cnt_d   = cnt_q;
    taken_d = taken_q;
    case (state_q)
      S_INIT: begin
        sweep_d = sweep_q + IDX_W'(1'b1);
        if (sweep_q == SWEEP_LAST) begin
          state_d = pending_s ? S_RD : S_IDLE;
        end else begin
          state_d = S_INIT;
        end
      end
      S_IDLE: state_d = pending_s ? S_RD : S_IDLE;
      S_RD: begin
        cnt_d   = tbl_rdata;
        taken_d = fifo_taken_q[rd_ptr_q];
        state_d = S_WR;
      end
      S_WR:    state_d = pending_s ? S_RD : S_IDLE;
      default: state_d = S_INIT;
    endcase
  end

  // Table write port: sweep clears during INIT, counter update during WR.
  always_comb begin
    tbl_we    = 1'b0;
    tbl_waddr = head_idx_s;
    tbl_wdata = 2'b00;
    if (run_s) begin
      case (state_q)
        S_INIT: begin
          tbl_we    = 1'b1;
          tbl_waddr = sweep_q;
        end
        S_WR: begin
          tbl_we    = 1'b1;
          tbl_wdata = sat_update(cnt_q, taken_q);
        end
        default: tbl_we = 1'b0;
      endcase
    end else begin
      tbl_we = 1'b0;
    end
  end

  // Control state, pointers and counters; everything holds while rdy_in is low.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q  <= S_INIT;
      sweep_q  <= {IDX_W{1'b0}};
      wr_ptr_q <= {PTR_W{1'b0}};
      rd_ptr_q <= {PTR_W{1'b0}};
      count_q  <= {CNT_W{1'b0}};
      cnt_q    <= 2'b00;
      taken_q  <= 1'b0;
`ifdef BP_STATS_EN
      stat_updates_q <= 32'd0;
      stat_mispred_q <= 32'd0;
`endif
    end else if (rdy_in) begin
      state_q <= state_d;
      sweep_q <= sweep_d;
      count_q <= count_d;
      cnt_q   <= cnt_d;
      taken_q <= taken_d;
      if (push_s) wr_ptr_q <= wr_ptr_q + PTR_W'(1'b1);
      if (pop_s)  rd_ptr_q <= rd_ptr_q + PTR_W'(1'b1);
`ifdef BP_STATS_EN
      if (pop_s) begin
        stat_updates_q <= stat_updates_q + 32'd1;
        if (fifo_mis_q[rd_ptr_q]) stat_mispred_q <= stat_mispred_q + 32'd1;
      end
`endif
    end
  end

  // FIFO payload storage; only the table index bits of the PC are kept.
  always_ff @(posedge clk_in) begin
    if (push_s) begin
      fifo_idx_q[wr_ptr_q]   <= upd_pc[IDX_W+1:2];
      fifo_taken_q[wr_ptr_q] <= upd_taken;
`ifdef BP_STATS_EN
      fifo_mis_q[wr_ptr_q]   <= upd_mispredict;
`endif
    end
  end

endmodule

// File: tb/tb_bp_update_ctrl.sv
// Scoreboard bench for bp_update_ctrl: a behavioural table/queue model predicts every table write,
// a negedge monitor pops and compares them, plus directed latency, stall and reset scenarios.
module tb_bp_update_ctrl;
  localparam int IDX_W = 7;
  localparam int DEPTH = 4;
  localparam int NENT  = 1 << IDX_W;

  logic             clk_in = 1'b0;
  logic             rst_in = 1'b1;
  logic             rdy_in = 1'b1;
  logic             upd_valid = 1'b0;
  logic [31:0]      upd_pc = 32'd0;
  logic             upd_taken = 1'b0;
  logic             upd_mispredict = 1'b0;
  logic             upd_ready, tbl_we, init_busy;
  logic [IDX_W-1:0] tbl_raddr, tbl_waddr;
  logic [1:0]       tbl_rdata, tbl_wdata;
`ifdef BP_STATS_EN
  logic [31:0]      stat_updates, stat_mispred;
`endif

  bp_update_ctrl #(.IDX_W(IDX_W), .FIFO_DEPTH(DEPTH)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
    .upd_mispredict(upd_mispredict), .upd_ready(upd_ready),
    .tbl_raddr(tbl_raddr), .tbl_rdata(tbl_rdata), .tbl_we(tbl_we),
    .tbl_waddr(tbl_waddr), .tbl_wdata(tbl_wdata),
`ifdef BP_STATS_EN
    .stat_updates(stat_updates), .stat_mispred(stat_mispred),
`endif
    .init_busy(init_busy));

  always #5 clk_in = ~clk_in;

  // The predictor table itself: one combinational read port, one write port.
  logic [1:0] mem [NENT];
  assign tbl_rdata = mem[tbl_raddr];
  always @(posedge clk_in) if (tbl_we) mem[tbl_waddr] <= tbl_wdata;

  typedef struct { int idx; int val; bit sweep; } exp_t;
  exp_t expq[$];
  int   ref_tbl [NENT];
  int   occ, checks, errors, held, stat_upd_exp, stat_mis_exp;
  int   cyc;
  int   wr_cyc[$];
  bit   rand_rdy;

  always @(posedge clk_in) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: per-cycle control checks and scoreboard pop on every table write.
  always @(negedge clk_in) begin
    exp_t e;
    if (rst_in) begin
      chk("we_in_reset", int'(tbl_we), 0);
      chk("ready_in_reset", int'(upd_ready), 0);
      chk("busy_in_reset", int'(init_busy), 1);
    end else begin
      chk("upd_ready", int'(upd_ready), (rdy_in && occ < DEPTH) ? 1 : 0);
      chk("init_busy", int'(init_busy), (expq.size() > 0 && expq[0].sweep) ? 1 : 0);
      if (!rdy_in) begin
        chk("we_while_stalled", int'(tbl_we), 0);
      end else if (tbl_we) begin
        if (expq.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_write addr=%0d data=%0d expected no write", tbl_waddr, tbl_wdata);
        end else begin
          e = expq.pop_front();
          chk("waddr", int'(tbl_waddr), e.idx);
          chk("wdata", int'(tbl_wdata), e.val);
          if (!e.sweep) begin
            occ--;
            wr_cyc.push_back(cyc);
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clk_in);
    #1;
    if (rand_rdy) rdy_in = ($urandom_range(0, 4) != 0);
  endtask

  task automatic do_reset(input int ncyc);
    rst_in = 1'b1;
    upd_valid = 1'b0;
    expq.delete();
    occ = 0;
    stat_upd_exp = 0;
    stat_mis_exp = 0;
    for (int i = 0; i < NENT; i++) begin
      ref_tbl[i] = 0;
      expq.push_back('{i, 0, 1'b1});
    end
    repeat (ncyc) step();
    rst_in = 1'b0;
  endtask

  function automatic logic [31:0] rpc(input int idx);
    return ($urandom() & 32'hFFFF_FE00) | (32'(idx) << 2) | 32'($urandom_range(0, 3));
  endfunction

  // Present one update and hold it until accepted; the model result is queued on acceptance.
  task automatic send(input logic [31:0] pc, input bit taken);
    bit acc;
    int idx, v;
    upd_pc = pc;
    upd_taken = taken;
    upd_mispredict = 1'($urandom_range(0, 1));
    upd_valid = 1'b1;
    acc = 1'b0;
    for (int k = 0; k < 200 && !acc; k++) begin
      @(negedge clk_in);
      acc = upd_ready;
      if (!acc) held++;
      step();
    end
    if (!acc) begin
      checks++; errors++;
      $display("FAIL accept_timeout pc=%08h never accepted", pc);
    end else begin
      idx = int'(pc[IDX_W+1:2]);
      v = ref_tbl[idx];
      v = taken ? ((v + 1 > 3) ? 3 : v + 1) : ((v - 1 < 0) ? 0 : v - 1);
      ref_tbl[idx] = v;
      expq.push_back('{idx, v, 1'b0});
      occ++;
      stat_upd_exp++;
      if (upd_mispredict) stat_mis_exp++;
    end
  endtask

  task automatic drain(input int budget);
    int k;
    upd_valid = 1'b0;
    k = 0;
    while (expq.size() != 0 && k < budget) begin
      step();
      k++;
    end
    if (expq.size() != 0) begin
      checks++; errors++;
      $display("FAIL drain_timeout pending=%0d expected 0", expq.size());
      expq.delete();
      occ = 0;
    end
  endtask

  initial begin
    rand_rdy = 1'b0;
    do_reset(3);
    drain(300);

    // Single update latency: accepted at edge E, RD in E+1, WR in E+2.
    send(32'h0000_0104, 1'b1);
    upd_valid = 1'b0;
    @(negedge clk_in);
    chk("lat_rd_we", int'(tbl_we), 0);
    chk("lat_rd_raddr", int'(tbl_raddr), 'h41);
    @(negedge clk_in);
    chk("lat_wr_we", int'(tbl_we), 1);
    drain(50);

    // Saturation at index 5, both ends.
    repeat (3) send(rpc(5), 1'b1);
    drain(50);
    send(rpc(5), 1'b1);
    drain(50);
    repeat (3) send(rpc(5), 1'b0);
    drain(50);
    send(rpc(5), 1'b0);
    drain(50);

    // Two back-to-back taken updates to one index starting at 01.
    send(rpc(16), 1'b1);
    drain(50);
    send(rpc(16), 1'b1);
    send(rpc(16), 1'b1);
    drain(50);

    // Back-pressure: eight back-to-back updates fill the FIFO.
    held = 0;
    wr_cyc.delete();
    for (int i = 0; i < 8; i++) send(rpc($urandom_range(0, NENT - 1)), 1'($urandom_range(0, 1)));
    drain(100);
    chk("bp_some_held", (held > 0) ? 1 : 0, 1);
    chk("bp_write_count", wr_cyc.size(), 8);
    for (int i = 1; i < wr_cyc.size(); i++) chk("bp_spacing", wr_cyc[i] - wr_cyc[i-1], 2);

    // rdy_in low for three cycles while in RD delays the write by exactly three cycles.
    send(rpc(33), 1'b1);
    upd_valid = 1'b0;
    rdy_in = 1'b0;
    repeat (3) begin
      @(negedge clk_in);
      chk("stall_we", int'(tbl_we), 0);
      step();
    end
    rdy_in = 1'b1;
    @(negedge clk_in);
    chk("stall_rd_we", int'(tbl_we), 0);
    chk("stall_rd_raddr", int'(tbl_raddr), 33);
    step();
    @(negedge clk_in);
    chk("stall_wr_we", int'(tbl_we), 1);
    drain(50);

    // Reset with entries queued: FIFO discarded, sweep restarts; updates accepted during INIT.
    for (int i = 0; i < 4; i++) send(rpc(64 + i), 1'b1);
    do_reset(1);
    send(rpc(9), 1'b1);
    send(rpc(9), 1'b1);
    drain(300);

    // Randomized traffic with random stalls and index collisions.
    rand_rdy = 1'b1;
    for (int n = 0; n < 300; n++) begin
      int gap;
      gap = $urandom_range(0, 3);
      if (gap != 0) begin
        upd_valid = 1'b0;
        repeat (gap) step();
      end
      send(rpc(($urandom_range(0, 1) != 0) ? $urandom_range(0, 3) : $urandom_range(0, NENT - 1)),
           1'($urandom_range(0, 1)));
    end
    drain(3000);
    rand_rdy = 1'b0;
    rdy_in = 1'b1;
    step();

`ifdef BP_STATS_EN
    chk("stat_updates", int'(stat_updates), stat_upd_exp);
    chk("stat_mispred", int'(stat_mispred), stat_mis_exp);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
